// File: rtl/gray_burst_pkg.sv
// Shared types and helpers for the Gray-code burst sequencer.
package gray_burst_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest count bin2gray handles; callers zero-extend in and truncate out.
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_counter.sv
// Loadable up/down binary counter with hold-enable; presents its value Gray-encoded.
module gray_step_counter
  import gray_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_val,
  input  logic                  i_en,
  input  logic                  i_down,
  output logic [DATA_WIDTH-1:0] o_gray
);

  logic [DATA_WIDTH-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation ordering cannot change the result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= (i_down == DIR_DOWN) ? r_cnt - DATA_WIDTH'(1) : r_cnt + DATA_WIDTH'(1);
    end
  end

  assign o_gray = DATA_WIDTH'(bin2gray(GRAY_MAX_W'(r_cnt)));

endmodule

// File: rtl/gray_burst_ctrl.sv
// Command-driven burst sequencer: accepts {start, len, dir} and streams the
// Gray encoding of each count over a valid/ready interface.
module gray_burst_ctrl
  import gray_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_start,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_down,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic                  gray_valid,
  input  logic                  gray_ready,
  output logic                  gray_last,
  output logic                  busy,
  output logic                  done
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_dir;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_gray;

  assign w_last = (r_rem == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dir   <= DIR_UP;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_xfer && w_last;
      if (w_accept) begin
        r_rem <= cmd_len;
        r_dir <= cmd_down;
      end else if (w_xfer && !w_last) begin
        r_rem <= r_rem - LEN_WIDTH'(1);
      end
    end
  end

  // Every output is gated by resetn so it reads 0 for the whole reset window.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    cmd_ready   = 1'b0;
    gray_valid  = 1'b0;
    gray_last   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = resetn;
        w_accept  = resetn && cmd_valid;
        if (w_accept) w_state_nxt = RUN;
      end
      RUN: begin
        gray_valid = resetn;
        busy       = resetn;
        gray_last  = resetn && w_last;
        w_xfer     = resetn && gray_ready;
        if (w_xfer && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  gray_step_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_counter (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_accept),
    .i_load_val (cmd_start),
    .i_en       (w_xfer && !w_last),
    .i_down     (r_dir),
    .o_gray     (w_gray)
  );

  assign gray_out = gray_valid ? w_gray : '0;
  assign done     = r_done && resetn;

endmodule

// File: tb/tb_gray_burst_ctrl.sv
// Self-checking bench for gray_burst_ctrl: directed scenarios plus randomized
// bursts compared against an arithmetic model of the Gray sequence.
module tb_gray_burst_ctrl;
  import gray_burst_pkg::*;

  localparam int W  = 4;
  localparam int LW = 8;
  localparam int M  = 1 << W;

  logic          clk        = 1'b0;
  logic          resetn     = 1'b0;
  logic          cmd_valid  = 1'b0;
  logic [W-1:0]  cmd_start  = '0;
  logic [LW-1:0] cmd_len    = '0;
  logic          cmd_down   = 1'b0;
  logic          gray_ready = 1'b0;
  logic          cmd_ready, gray_valid, gray_last, busy, done;
  logic [W-1:0]  gray_out;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_gray[$];
  logic         obs_last[$];
  logic [W-1:0] stall_gray[$];
  logic         stall_last[$];
  bit done_now, ready_now, done_after, first_valid, ready_in_run, timeout;
  int unstable, gaps, run_cycles;

  always #5 clk = ~clk;

  gray_burst_ctrl #(.DATA_WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_len    (cmd_len),
    .cmd_down   (cmd_down),
    .gray_out   (gray_out),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready),
    .gray_last  (gray_last),
    .busy       (busy),
    .done       (done)
  );

  // Reference: count k of the burst is start +/- k modulo 2^W, then Gray-coded.
  function automatic void model_burst(input int st, input int ln, input bit dn);
    int c;
    exp_q.delete();
    for (int k = 0; k <= ln; k++) begin
      c = dn ? st - k : st + k;
      c = ((c % M) + M) % M;
      exp_q.push_back(W'(c ^ (c >> 1)));
    end
  endfunction

  // Drives one command and collects every transferred beat plus handshake observations.
  task automatic run_burst(input logic [W-1:0] st, input logic [LW-1:0] ln, input logic dn,
                           input int stall_pct, input int stall_at, input int stall_n,
                           input bit hold_valid);
    int cyc, stalls;
    bit fin, stalled;
    logic [W-1:0] pg;
    logic         pl;
    obs_gray.delete(); obs_last.delete(); stall_gray.delete(); stall_last.delete();
    done_now = 0; ready_now = 0; done_after = 1; first_valid = 0; ready_in_run = 0;
    timeout = 0; unstable = 0; gaps = 0; run_cycles = 0;
    pg = '0; pl = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = st; cmd_len = ln; cmd_down = dn; gray_ready = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!cmd_ready) begin
      timeout = 1;
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = hold_valid; cmd_start = ~st; cmd_len = '0; cmd_down = ~dn;
    first_valid = gray_valid;
    fin = 0; stalled = 0; stalls = 0; cyc = 0;
    while (!fin && cyc < 5000) begin
      if (!gray_valid) gaps++;
      if (cmd_ready) ready_in_run = 1;
      if (stalled && (gray_out !== pg || gray_last !== pl)) unstable++;
      if (obs_gray.size() == stall_at && stalls < stall_n) begin
        gray_ready = 1'b0;
        stalls++;
      end else begin
        gray_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      if (gray_valid && gray_ready) begin
        obs_gray.push_back(gray_out);
        obs_last.push_back(gray_last);
        if (gray_last) fin = 1;
        stalled = 0;
      end else if (gray_valid) begin
        stalled = 1; pg = gray_out; pl = gray_last;
        stall_gray.push_back(gray_out);
        stall_last.push_back(gray_last);
      end
      @(negedge clk);
      cyc++;
    end
    run_cycles = cyc;
    if (!fin) timeout = 1;
    gray_ready = 1'b0;
    cmd_valid  = 1'b0;
    done_now   = done;
    ready_now  = cmd_ready;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({cmd_ready, gray_valid, gray_last, busy, done, gray_out} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b busy=%b done=%b gray=%h, expected all 0",
               cmd_ready, gray_valid, gray_last, busy, done, gray_out);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || gray_valid !== 1'b0 || gray_out !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got rdy=%b busy=%b vld=%b gray=%h, expected 1 0 0 0",
               cmd_ready, busy, gray_valid, gray_out);
    end
  endtask

  task automatic test_basic_up();
    logic [W-1:0] e [8];
    e = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4};
    run_burst(4'd0, 8'd7, DIR_UP, 0, -1, 0, 1'b0);
    n_vec++;
    if (timeout || obs_gray.size() != 8 || run_cycles != 8 || first_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_shape: got beats=%0d cycles=%0d first_valid=%b timeout=%b, expected 8 8 1 0",
               obs_gray.size(), run_cycles, first_valid, timeout);
    end
    for (int i = 0; i < 8 && i < obs_gray.size(); i++) begin
      n_vec++;
      if (obs_gray[i] !== e[i] || obs_last[i] !== (i == 7)) begin
        n_err++;
        $display("FAIL basic_beat%0d: got gray=%h last=%b, expected gray=%h last=%b",
                 i, obs_gray[i], obs_last[i], e[i], (i == 7));
      end
    end
    n_vec++;
    if (done_now !== 1'b1 || ready_now !== 1'b1 || done_after !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got done=%b rdy=%b done_next=%b, expected 1 1 0",
               done_now, ready_now, done_after);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] eu [4];
    logic [W-1:0] ed [4];
    eu = '{4'h9, 4'h8, 4'h0, 4'h1};
    ed = '{4'h3, 4'h1, 4'h0, 4'h8};
    run_burst(4'd14, 8'd3, DIR_UP, 0, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= obs_gray.size() || obs_gray[i] !== eu[i]) begin
        n_err++;
        $display("FAIL wrap_up_beat%0d: got %h (beats=%0d), expected %h",
                 i, (i < obs_gray.size()) ? obs_gray[i] : 4'hx, obs_gray.size(), eu[i]);
      end
    end
    run_burst(4'd2, 8'd3, DIR_DOWN, 0, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= obs_gray.size() || obs_gray[i] !== ed[i]) begin
        n_err++;
        $display("FAIL wrap_down_beat%0d: got %h (beats=%0d), expected %h",
                 i, (i < obs_gray.size()) ? obs_gray[i] : 4'hx, obs_gray.size(), ed[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e [4];
    e = '{4'h0, 4'h1, 4'h3, 4'h2};
    run_burst(4'd0, 8'd3, DIR_UP, 0, 1, 3, 1'b0);
    n_vec++;
    if (stall_gray.size() != 3 || unstable != 0 || gaps != 0) begin
      n_err++;
      $display("FAIL bp_shape: got stalls=%0d unstable=%0d gaps=%0d, expected 3 0 0",
               stall_gray.size(), unstable, gaps);
    end
    for (int i = 0; i < stall_gray.size(); i++) begin
      n_vec++;
      if (stall_gray[i] !== 4'h1 || stall_last[i] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got gray=%h last=%b, expected gray=1 last=0",
                 i, stall_gray[i], stall_last[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= obs_gray.size() || obs_gray[i] !== e[i]) begin
        n_err++;
        $display("FAIL bp_beat%0d: got %h (beats=%0d), expected %h",
                 i, (i < obs_gray.size()) ? obs_gray[i] : 4'hx, obs_gray.size(), e[i]);
      end
    end
  endtask

  task automatic test_single_ignored();
    run_burst(4'd5, 8'd0, DIR_UP, 0, -1, 0, 1'b1);
    n_vec++;
    if (obs_gray.size() != 1 || obs_gray[0] !== 4'h7 || obs_last[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_beat: got beats=%0d gray=%h last=%b, expected 1 beat gray=7 last=1",
               obs_gray.size(), (obs_gray.size() > 0) ? obs_gray[0] : 4'hx,
               (obs_last.size() > 0) ? obs_last[0] : 1'bx);
    end
    n_vec++;
    if (ready_in_run !== 1'b0 || done_now !== 1'b1 || ready_now !== 1'b1) begin
      n_err++;
      $display("FAIL single_ignore: got rdy_in_run=%b done=%b rdy_at_done=%b, expected 0 1 1",
               ready_in_run, done_now, ready_now);
    end
    run_burst(4'd9, 8'd1, DIR_DOWN, 0, -1, 0, 1'b0);
    n_vec++;
    if (obs_gray.size() != 2 || obs_gray[0] !== 4'hd || obs_gray[1] !== 4'hc) begin
      n_err++;
      $display("FAIL back_to_back: got beats=%0d, expected d,c", obs_gray.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 4'd3; cmd_len = 8'd7; cmd_down = DIR_UP; gray_ready = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (gray_out !== 4'h7 || gray_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_beat3: got gray=%h vld=%b, expected 7 1", gray_out, gray_valid);
    end
    resetn = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({cmd_ready, gray_valid, gray_last, busy, done, gray_out} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got rdy=%b vld=%b last=%b busy=%b done=%b gray=%h, expected all 0",
               cmd_ready, gray_valid, gray_last, busy, done, gray_out);
    end
    resetn = 1'b1;
    gray_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || gray_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_recover: got rdy=%b done=%b vld=%b, expected 1 0 0",
               cmd_ready, done, gray_valid);
    end
    run_burst(4'd11, 8'd4, DIR_DOWN, 20, -1, 0, 1'b0);
    model_burst(11, 4, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= obs_gray.size() || obs_gray[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rst_mid_after_beat%0d: got %h (beats=%0d), expected %h",
                 i, (i < obs_gray.size()) ? obs_gray[i] : 4'hx, obs_gray.size(), exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  st;
    logic [LW-1:0] ln;
    logic          dn;
    for (int b = 0; b < 25; b++) begin
      st = W'($urandom);
      ln = (b == 12) ? LW'(255) : LW'($urandom_range(0, 15));
      dn = 1'($urandom);
      run_burst(st, ln, dn, $urandom_range(0, 50), -1, 0, 1'($urandom));
      model_burst(int'(st), int'(ln), dn);
      n_vec++;
      if (timeout || obs_gray.size() != exp_q.size() || unstable != 0 || gaps != 0 ||
          done_now !== 1'b1 || done_after !== 1'b0 || ready_in_run !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_handshake: beats=%0d/%0d timeout=%b unstable=%0d gaps=%0d done=%b,%b rdy_in_run=%b",
                 b, obs_gray.size(), exp_q.size(), timeout, unstable, gaps, done_now, done_after, ready_in_run);
      end
      for (int i = 0; i < exp_q.size() && i < obs_gray.size(); i++) begin
        n_vec++;
        if (obs_gray[i] !== exp_q[i] || obs_last[i] !== (i == exp_q.size() - 1)) begin
          n_err++;
          $display("FAIL rand%0d_beat%0d: got gray=%h last=%b, expected gray=%h last=%b",
                   b, i, obs_gray[i], obs_last[i], exp_q[i], (i == exp_q.size() - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_wrap();
    test_backpressure();
    test_single_ignored();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
